hs_frame_parser: RTL and testbench
==================================

// Module: hs_frame_parser
// PURPOSE
//  Consumes the byte bursts leaving the high-speed receive stage (o_hs_data / o_hs_data_valid, i_clk100m domain).
//  Hunts for sync header 0xEB 0x90, then reads a length byte, LEN payload bytes and an 8-bit checksum byte.
//  Streams the payload downstream with SOP/EOP markers and issues a per-frame verdict.
//  Keeps saturating good-frame and error counters for status registers.
// PARAMETERS
//  MAX_LEN   200  largest legal LEN value (1..255); larger values are rejected
//  GAP_TO    16   idle cycles without a valid byte, mid-frame, before the frame is aborted (2..255)
// PORTS
//  i_clk100m        in   1   single clock, 100 MHz
//  i_rst            in   1   synchronous reset, active-high
//  i_hs_data        in   8   byte from the high-speed receive stage
//  i_hs_data_valid  in   1   byte qualifier; no backpressure, one byte per cycle when high
//  o_pl_data        out  8   payload byte
//  o_pl_valid       out  1   payload byte qualifier
//  o_pl_sop         out  1   first payload byte of a frame (qualified by o_pl_valid)
//  o_pl_eop         out  1   last payload byte of a frame (qualified by o_pl_valid)
//  o_frame_done     out  1   1-cycle pulse: frame finished or aborted
//  o_frame_ok       out  1   valid with o_frame_done: 1 = checksum good
//  o_err_code       out  2   valid with o_frame_done: 0 none, 1 bad LEN, 2 bad checksum, 3 gap timeout
//  o_frame_cnt      out  16  good frames, saturates at 0xFFFF
//  o_err_cnt        out  16  failed frames (any error code), saturates at 0xFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, state HUNT, checksum accumulator 0, gap counter 0. Reset mid-frame discards the frame silently.
//  - States and transitions (a transition consumes one valid byte unless noted):
//    HUNT: byte 0xEB -> SYNC1; any other byte -> stay.
//    SYNC1: 0x90 -> LEN; 0xEB -> stay in SYNC1; other -> HUNT.
//    LEN: LEN==0 or LEN>MAX_LEN -> abort with err 1 and go to HUNT. Otherwise latch LEN, sum=LEN, go to PAYLOAD.
//    PAYLOAD: forward the byte, sum+=byte (mod 256), count bytes; after the LEN-th byte -> CSUM.
//    CSUM: byte==sum -> done with ok=1, err 0; else done with ok=0, err 2; go to HUNT.
//  - Payload output is registered with 1-cycle latency: o_pl_* follow the input byte by exactly one clock.
//    o_pl_sop marks payload byte 1, o_pl_eop marks payload byte LEN; both are high together when LEN==1.
//  - o_frame_done pulses 1 cycle after the terminating byte (checksum byte, or the bad LEN byte).
//    o_frame_ok and o_err_code are valid only in that cycle and are 0 otherwise.
//  - Gap timeout: the gap counter clears on every valid byte and increments otherwise while in SYNC1/LEN/PAYLOAD/CSUM.
//    When it reaches GAP_TO, the block pulses done with ok=0, err 3 and returns to HUNT. No EOP is emitted for an aborted payload.
//    A valid byte in the cycle the counter would reach GAP_TO takes priority and resets the counter.
//    The counter is idle in HUNT.
//  - An abort leaves no residue: the next 0xEB 0x90 starts a fresh frame. Bytes after the checksum byte are hunted normally.
//  - Counters: o_frame_cnt increments on done&&ok; o_err_cnt increments on done&&!ok. Both hold at 0xFFFF.
//  - Checksum is the 8-bit two's-complement wrap sum of the LEN byte and all payload bytes. Sync bytes are excluded.
// STRUCTURE
//  - Package hs_frame_pkg: SYNC0=8'hEB, SYNC1=8'h90, state encoding (HUNT,SYNC1,LEN,PAYLOAD,CSUM), err codes ERR_NONE/LEN/CSUM/GAP.
//  - One sub-module: hs_gap_timer (clear, enable, GAP_TO -> expire pulse).
//  - The rest is a single FSM with a datapath: LEN register, byte counter, sum accumulator, output registers and saturating counters.
// TESTING
//  1. EB 90 03 11 22 33 69 -> payload 11,22,33 with SOP on 11 and EOP on 33; done, ok=1, err 0; frame_cnt=1.
//  2. Same frame with checksum byte 68 -> payload still streamed; done, ok=0, err 2; err_cnt=1, frame_cnt unchanged.
//  3. Noise 00 EB EB 90 01 AA AB -> one frame, SOP and EOP both on AA, ok=1; leading bytes ignored.
//  4. EB 90 C9 (201 > MAX_LEN) -> done err 1 one cycle later, no o_pl_valid. EB 90 00 -> also err 1.
//  5. EB 90 04 01 02, then valid low for 16 cycles -> done err 3, no EOP; a following good frame passes, ok=1.
//  6. Assert i_rst during payload -> all outputs 0 next cycle, no done pulse; 0xFFFF+1 good frames -> frame_cnt stays 0xFFFF.

Source files
------------

// File: rtl/hs_frame_parser_pkg.sv
// hs_frame_pkg: sync bytes, FSM state encoding and verdict codes shared by the frame parser
package hs_frame_pkg;
    localparam logic [7:0] SYNC0 = 8'hEB;
    localparam logic [7:0] SYNC1 = 8'h90;
    typedef enum logic [2:0] {ST_HUNT, ST_SYNC1, ST_LEN, ST_PAYLOAD, ST_CSUM} state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_GAP} err_t;
endpackage

// File: rtl/hs_frame_parser_if.sv
// hs_frame_parser_if: receive byte stream in, payload stream, verdict and status counters out
// slave  (parser): takes i_hs_data/i_hs_data_valid, drives o_pl_*, o_frame_*, o_err_code, o_*_cnt
// master (source): drives i_hs_*, observes everything else
interface hs_frame_parser_if;
    logic [7:0]  i_hs_data;
    logic        i_hs_data_valid;
    logic [7:0]  o_pl_data;
    logic        o_pl_valid;
    logic        o_pl_sop;
    logic        o_pl_eop;
    logic        o_frame_done;
    logic        o_frame_ok;
    logic [1:0]  o_err_code;
    logic [15:0] o_frame_cnt;
    logic [15:0] o_err_cnt;
    modport slave (
        input  i_hs_data, i_hs_data_valid,
        output o_pl_data, o_pl_valid, o_pl_sop, o_pl_eop,
        output o_frame_done, o_frame_ok, o_err_code, o_frame_cnt, o_err_cnt
    );
    modport master (
        output i_hs_data, i_hs_data_valid,
        input  o_pl_data, o_pl_valid, o_pl_sop, o_pl_eop,
        input  o_frame_done, o_frame_ok, o_err_code, o_frame_cnt, o_err_cnt
    );
endinterface

// File: rtl/hs_frame_parser_gap_timer.sv
// hs_gap_timer: counts idle cycles while enabled, pulses o_expire in the cycle the count would reach GAP_TO
// ports: i_clk100m/i_rst clock and sync reset, i_clear restart on a valid byte, i_enable count while mid-frame, o_expire abort pulse
module hs_gap_timer #(
    parameter int GAP_TO = 16
) (
    input  logic i_clk100m,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    logic [7:0] r_cnt;
    // a valid byte in the would-be expiry cycle wins, so i_clear masks the pulse
    assign o_expire = i_enable && !i_clear && r_cnt == 8'(GAP_TO - 1);
    always_ff @(posedge i_clk100m)
        r_cnt <= (i_rst || i_clear || !i_enable || o_expire) ? 8'd0 : r_cnt + 8'd1;
endmodule

// File: rtl/hs_frame_parser.sv
// hs_frame_parser: hunts EB 90 sync, parses LEN/payload/checksum, streams payload and reports per-frame verdicts
// ports: i_clk100m clock, i_rst sync active-high reset, bus (slave) byte input, payload stream, verdict, saturating counters
module hs_frame_parser
    import hs_frame_pkg::*;
#(
    parameter int          MAX_LEN = 200,
    parameter int          GAP_TO  = 16,
    parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
    input  logic            i_clk100m,
    input  logic            i_rst,
    hs_frame_parser_if.slave bus
);
    localparam logic [7:0] LP_MAX_LEN = 8'(MAX_LEN);
    state_t      r_state, w_nxt;
    err_t        w_err;
    logic [7:0]  r_len, r_cnt, r_sum, r_pl_data;
    logic [1:0]  r_err;
    logic [15:0] r_frame_cnt, r_err_cnt;
    logic        r_pl_valid, r_sop, r_eop, r_done, r_ok;
    logic        w_v, w_expire, w_last, w_pl, w_sop, w_eop, w_len_bad, w_csum, w_ok, w_done;
    logic [7:0]  w_d;
    assign w_v = bus.i_hs_data_valid;
    assign w_d = bus.i_hs_data;
    assign w_last = r_cnt == r_len - 8'd1;
    hs_gap_timer #(.GAP_TO(GAP_TO)) u_gap (
        .i_clk100m(i_clk100m),
        .i_rst(i_rst),
        .i_clear(w_v),
        .i_enable(r_state != ST_HUNT),
        .o_expire(w_expire)
    );
    always_ff @(posedge i_clk100m)
        r_state <= i_rst ? ST_HUNT : w_nxt;
    always_comb begin
        w_nxt = r_state;
        if (w_expire)
            w_nxt = ST_HUNT;
        else if (w_v)
            case (r_state)
                ST_HUNT:    w_nxt = (w_d == SYNC0) ? ST_SYNC1 : ST_HUNT;
                ST_SYNC1:   w_nxt = (w_d == SYNC1) ? ST_LEN : (w_d == SYNC0) ? ST_SYNC1 : ST_HUNT;
                ST_LEN:     w_nxt = w_len_bad ? ST_HUNT : ST_PAYLOAD;
                ST_PAYLOAD: w_nxt = w_last ? ST_CSUM : ST_PAYLOAD;
                default:    w_nxt = ST_HUNT;
            endcase
    end
    always_comb begin
        w_pl      = w_v && r_state == ST_PAYLOAD;
        w_sop     = w_pl && r_cnt == 8'd0;
        w_eop     = w_pl && w_last;
        w_len_bad = w_v && r_state == ST_LEN && (w_d == 8'd0 || w_d > LP_MAX_LEN);
        w_csum    = w_v && r_state == ST_CSUM;
        w_ok      = w_csum && w_d == r_sum;
        w_done    = w_len_bad || w_csum || w_expire;
        w_err     = w_len_bad ? ERR_LEN : (w_csum && !w_ok) ? ERR_CSUM : w_expire ? ERR_GAP : ERR_NONE;
    end
    always_ff @(posedge i_clk100m) begin
        if (i_rst) begin
            {r_len, r_cnt, r_sum, r_pl_data} <= '0;
            {r_pl_valid, r_sop, r_eop, r_done, r_ok, r_err} <= '0;
            {r_frame_cnt, r_err_cnt} <= '0;
        end else begin
            r_pl_data  <= w_pl ? w_d : 8'h00;
            r_pl_valid <= w_pl;
            r_sop      <= w_sop;
            r_eop      <= w_eop;
            r_done     <= w_done;
            r_ok       <= w_ok;
            r_err      <= w_err;
            // a bad LEN byte also lands here but the frame is dropped, so the stale values never matter
            if (w_v && r_state == ST_LEN) begin
                r_len <= w_d;
                r_sum <= w_d;
                r_cnt <= 8'd0;
            end
            if (w_pl) begin
                r_sum <= r_sum + w_d;
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_done && w_ok && r_frame_cnt != CNT_MAX)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_done && !w_ok && r_err_cnt != CNT_MAX)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end
    assign bus.o_pl_data    = r_pl_data;
    assign bus.o_pl_valid   = r_pl_valid;
    assign bus.o_pl_sop     = r_sop;
    assign bus.o_pl_eop     = r_eop;
    assign bus.o_frame_done = r_done;
    assign bus.o_frame_ok   = r_ok;
    assign bus.o_err_code   = r_err;
    assign bus.o_frame_cnt  = r_frame_cnt;
    assign bus.o_err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_hs_frame_parser.sv
// tb_hs_frame_parser: frame-level stimulus whose expected outputs follow from how each frame is built
module tb_hs_frame_parser;
    import hs_frame_pkg::*;
    localparam int          MAX_LEN = 200;
    localparam int          GAP_TO  = 16;
    localparam logic [15:0] CNT_MAX = 16'd40;
    logic i_clk100m = 1'b0;
    logic i_rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   m_good = 0;
    int   m_bad = 0;
    bit   use_gaps = 0;
    hs_frame_parser_if bus();
    hs_frame_parser #(.MAX_LEN(MAX_LEN), .GAP_TO(GAP_TO), .CNT_MAX(CNT_MAX)) dut (
        .i_clk100m(i_clk100m),
        .i_rst(i_rst),
        .bus(bus)
    );
    always #5 i_clk100m = ~i_clk100m;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask
    function automatic logic [31:0] obs();
        return {17'd0, bus.o_pl_valid, bus.o_pl_sop, bus.o_pl_eop, bus.o_frame_done,
                bus.o_frame_ok, bus.o_err_code, bus.o_pl_valid ? bus.o_pl_data : 8'h00};
    endfunction
    task automatic check_cnts();
        check("frame_cnt", 32'(bus.o_frame_cnt), 32'(m_good));
        check("err_cnt", 32'(bus.o_err_cnt), 32'(m_bad));
    endtask
    // one clock: drive, let the DUT sample, then compare the registered response to that byte
    task automatic step(bit v, logic [7:0] d, bit ev = 0, bit sop = 0, bit eop = 0,
                        bit done = 0, bit ok = 0, logic [1:0] err = 2'd0);
        bus.i_hs_data_valid = v;
        bus.i_hs_data = v ? d : 8'($urandom);
        @(posedge i_clk100m);
        #1;
        if (done && ok && m_good < int'(CNT_MAX)) m_good++;
        if (done && !ok && m_bad < int'(CNT_MAX)) m_bad++;
        check("out", obs(), {17'd0, ev, sop, eop, done, ok, err, ev ? d : 8'h00});
        check_cnts();
    endtask
    task automatic gap(int n);
        repeat (n) step(0, 8'h00);
    endtask
    function automatic int pre_gap();
        int r = int'($urandom_range(0, 9));
        if (!use_gaps || r < 7) return 0;
        return (r < 9) ? int'($urandom_range(1, 3)) : GAP_TO - 1;
    endfunction
    task automatic fbyte(logic [7:0] d, bit ev = 0, bit sop = 0, bit eop = 0,
                         bit done = 0, bit ok = 0, logic [1:0] err = 2'd0);
        gap(pre_gap());
        step(1, d, ev, sop, eop, done, ok, err);
    endtask
    task automatic abort_gap();
        gap(GAP_TO - 1);
        step(0, 8'h00, 0, 0, 0, 1, 0, ERR_GAP);
    endtask
    // ab: -2 no abort, -1 stall before LEN, i stall before payload byte i, len stall before checksum
    task automatic frame(int len, bit bad, int ab);
        logic [7:0] sum = 8'(len);
        logic [7:0] b;
        fbyte(SYNC0);
        fbyte(SYNC1);
        if (ab == -1) begin
            abort_gap();
            return;
        end
        if (len == 0 || len > MAX_LEN) begin
            fbyte(8'(len), 0, 0, 0, 1, 0, ERR_LEN);
            return;
        end
        fbyte(8'(len));
        for (int i = 0; i < len; i++) begin
            if (ab == i) begin
                abort_gap();
                return;
            end
            b = 8'($urandom);
            sum = sum + b;
            fbyte(b, 1, i == 0, i == len - 1);
        end
        if (ab == len) begin
            abort_gap();
            return;
        end
        fbyte(bad ? sum + 8'($urandom_range(1, 255)) : sum, 0, 0, 0, 1, !bad, bad ? ERR_CSUM : ERR_NONE);
    endtask
    task automatic noise(int n);
        logic [7:0] b;
        repeat (n) begin
            b = 8'($urandom);
            fbyte(b == SYNC1 ? 8'h91 : b);
        end
    endtask
    task automatic rframe();
        int k = int'($urandom_range(0, 9));
        int len = int'($urandom_range(1, 12));
        int ab = -2;
        if (k == 6) len = $urandom_range(0, 1) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
        if (k == 9) len = $urandom_range(0, 1) ? 1 : MAX_LEN;
        if (k == 7 || k == 8) ab = int'($urandom_range(0, len + 1)) - 1;
        noise(int'($urandom_range(0, 3)));
        frame(len, k == 4 || k == 5, ab);
        gap(int'($urandom_range(0, 20)));
    endtask
    initial begin
        bus.i_hs_data = 8'h00;
        bus.i_hs_data_valid = 1'b0;
        repeat (3) @(posedge i_clk100m);
        #1;
        check("rst_out", obs(), 32'd0);
        check("rst_data", 32'(bus.o_pl_data), 32'd0);
        check_cnts();
        i_rst = 1'b0;
        fbyte(8'hEB); fbyte(8'h90); fbyte(8'h03);
        fbyte(8'h11, 1, 1, 0); fbyte(8'h22, 1); fbyte(8'h33, 1, 0, 1);
        fbyte(8'h69, 0, 0, 0, 1, 1, ERR_NONE);
        fbyte(8'hEB); fbyte(8'h90); fbyte(8'h03);
        fbyte(8'h11, 1, 1, 0); fbyte(8'h22, 1); fbyte(8'h33, 1, 0, 1);
        fbyte(8'h68, 0, 0, 0, 1, 0, ERR_CSUM);
        fbyte(8'h00); fbyte(8'hEB); fbyte(8'hEB); fbyte(8'h90); fbyte(8'h01);
        fbyte(8'hAA, 1, 1, 1);
        fbyte(8'hAB, 0, 0, 0, 1, 1, ERR_NONE);
        fbyte(8'hEB); fbyte(8'h90); fbyte(8'hC9, 0, 0, 0, 1, 0, ERR_LEN);
        fbyte(8'hEB); fbyte(8'h90); fbyte(8'h00, 0, 0, 0, 1, 0, ERR_LEN);
        fbyte(8'hEB); fbyte(8'h90); fbyte(8'h04);
        fbyte(8'h01, 1, 1, 0); fbyte(8'h02, 1);
        abort_gap();
        frame(3, 0, -2);
        fbyte(8'hEB); fbyte(8'h90); fbyte(8'h02);
        gap(GAP_TO - 1);
        fbyte(8'h05, 1, 1, 0);
        gap(GAP_TO - 1);
        fbyte(8'h06, 1, 0, 1);
        fbyte(8'h0D, 0, 0, 0, 1, 1, ERR_NONE);
        gap(GAP_TO + 4);
        fbyte(8'hEB); fbyte(8'h90); fbyte(8'h05);
        fbyte(8'h01, 1, 1, 0); fbyte(8'h02, 1);
        i_rst = 1'b1;
        bus.i_hs_data = 8'h03;
        bus.i_hs_data_valid = 1'b1;
        @(posedge i_clk100m);
        #1;
        m_good = 0;
        m_bad = 0;
        check("rst_mid_out", obs(), 32'd0);
        check("rst_mid_data", 32'(bus.o_pl_data), 32'd0);
        check_cnts();
        i_rst = 1'b0;
        fbyte(8'h04);
        fbyte(8'h05);
        frame(2, 0, -2);
        use_gaps = 1;
        repeat (160) rframe();
        use_gaps = 0;
        repeat (45) frame(1, 0, -2);
        repeat (45) frame(1, 1, -2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
